dcache_snoop_responder: RTL



---
 rtl/cpu_types_pkg.sv | 48 ++++
 rtl/dcache_snoop_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared CPU/cache types used by the dcache snoop responder:
//   word_t       - 32-bit machine word
//   dcachef_t    - dcache byte-address split: tag / idx / blkoff / bytoff
//                  (8 sets, 2-word blocks, 4-byte words)
//   snp_state_t  - snoop responder FSM states
//   blk_base()   - block base address of a byte address (block offset cleared)
// -----------------------------------------------------------------------------
package cpu_types_pkg;

   localparam int WORD_W    = 32;
   localparam int DC_BYT_W  = 2;
   localparam int DC_BLK_W  = 1;
   localparam int DC_IDX_W  = 3;
   localparam int DC_TAG_W  = WORD_W - DC_IDX_W - DC_BLK_W - DC_BYT_W;

   // Bit position of the set index inside a byte address.
   localparam int DC_IDX_LSB = DC_BYT_W + DC_BLK_W;

   typedef logic [WORD_W-1:0] word_t;

   typedef struct packed {
      logic [DC_TAG_W-1:0] tag;
      logic [DC_IDX_W-1:0] idx;
      logic [DC_BLK_W-1:0] blkoff;
      logic [DC_BYT_W-1:0] bytoff;
   } dcachef_t;

   typedef enum logic [2:0] {
      SNP_IDLE   = 3'd0,
      SNP_LOOKUP = 3'd1,
      SNP_XFER0  = 3'd2,
      SNP_XFER1  = 3'd3,
      SNP_UPDATE = 3'd4,
      SNP_HOLD   = 3'd5
   } snp_state_t;

   // Snoop addresses are looked up and forwarded as whole blocks, so the
   // word-within-block select is cleared; the byte offset is left untouched.
   function automatic word_t blk_base(input word_t addr);
      dcachef_t f;
      f        = dcachef_t'(addr);
      f.blkoff = '0;
      return word_t'(f);
   endfunction

endpackage

// File: rtl/dcache_snoop_responder.sv
// -----------------------------------------------------------------------------
// dcache_snoop_responder
// Cache-side MSI snoop responder, one per L1 dcache. On ccwait the snoop
// address is latched and looked up in the local frame array. A Modified hit
// raises snp_cctrans and streams both block words (paced by dwait), then the
// frame is downgraded M->S or invalidated (ccinv). A clean hit only honours
// ccinv. The cache muxes its bus outputs to this block while snp_active is high.
//
// Parameters : SETS (8), WAYS (2)
// Inputs     : CLK, nRST (async active-low), ccwait, ccinv, ccsnoopaddr, dwait,
//              frm_hit/frm_valid/frm_dirty/frm_way/frm_data0/frm_data1
//              (combinational frame lookup of snp_addr)
// Outputs    : snp_addr, snp_active, snp_cctrans, snp_daddr, snp_dstore,
//              upd_en/upd_idx/upd_way/upd_valid/upd_dirty (frame state write),
//              link_clr (only when SNOOP_LINK_CLR_EN is defined)
// All outputs are registered; they are computed from the next state so each
// one is valid in the same cycle as the state it belongs to.
// -----------------------------------------------------------------------------
module dcache_snoop_responder
   import cpu_types_pkg::*;
#(
   parameter int SETS = 8,
   parameter int WAYS = 2
) (
   input  logic                    CLK,
   input  logic                    nRST,
   input  logic                    ccwait,
   input  logic                    ccinv,
   input  word_t                   ccsnoopaddr,
   input  logic                    dwait,
   input  logic                    frm_hit,
   input  logic                    frm_valid,
   input  logic                    frm_dirty,
   input  logic [$clog2(WAYS)-1:0] frm_way,
   input  word_t                   frm_data0,
   input  word_t                   frm_data1,
   output word_t                   snp_addr,
   output logic                    snp_active,
   output logic                    snp_cctrans,
   output word_t                   snp_daddr,
   output word_t                   snp_dstore,
   output logic                    upd_en,
   output logic [$clog2(SETS)-1:0] upd_idx,
   output logic [$clog2(WAYS)-1:0] upd_way,
   output logic                    upd_valid,
   output logic                    upd_dirty
`ifdef SNOOP_LINK_CLR_EN
   ,
   output logic                    link_clr
`endif
);

   localparam int IDX_W = $clog2(SETS);
   localparam int WAY_W = $clog2(WAYS);

   snp_state_t       state_q, state_d;
   word_t            addr_q, addr_d;
   logic             inv_q, inv_d;
   logic [WAY_W-1:0] way_q, way_d;
   word_t            data0_q, data0_d;
   word_t            data1_q, data1_d;

   logic             active_q, active_d;
   logic             cctrans_q, cctrans_d;
   word_t            daddr_q, daddr_d;
   word_t            dstore_q, dstore_d;
   logic             upd_en_q, upd_en_d;
   logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
   logic [WAY_W-1:0] upd_way_q, upd_way_d;
   logic             upd_valid_q, upd_valid_d;
   logic             upd_dirty_q, upd_dirty_d;

   logic             hit_s;
   logic             mod_hit_s;

   assign hit_s     = frm_hit & frm_valid;
   assign mod_hit_s = hit_s & frm_dirty;

   // Next-state and latch logic of the snoop FSM.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      inv_d   = inv_q;
      way_d   = way_q;
      data0_d = data0_q;
      data1_d = data1_q;
      case (state_q)
         SNP_IDLE: begin
            if (ccwait) begin
               addr_d  = blk_base(ccsnoopaddr);
               state_d = SNP_LOOKUP;
            end else begin
               state_d = SNP_IDLE;
            end
         end
         SNP_LOOKUP: begin
            // ccinv is captured only here; later toggles are ignored.
            inv_d   = ccinv;
            way_d   = frm_way;
            data0_d = frm_data0;
            data1_d = frm_data1;
            if (mod_hit_s) begin
               state_d = SNP_XFER0;
            end else if (hit_s && ccinv) begin
               state_d = SNP_UPDATE;
            end else begin
               state_d = SNP_HOLD;
            end
         end
         SNP_XFER0: begin
            if (!dwait) begin
               state_d = SNP_XFER1;
            end else begin
               state_d = SNP_XFER0;
            end
         end
         SNP_XFER1: begin
            if (!dwait) begin
               state_d = SNP_UPDATE;
            end else begin
               state_d = SNP_XFER1;
            end
         end
         SNP_UPDATE: begin
            state_d = SNP_HOLD;
         end
         SNP_HOLD: begin
            // ccwait stays high while the controller fetches from memory;
            // waiting for it to drop keeps us from answering the same snoop twice.
            if (!ccwait) begin
               state_d = SNP_IDLE;
            end else begin
               state_d = SNP_HOLD;
            end
         end
         default: begin
            state_d = SNP_IDLE;
         end
      endcase
   end

   // Output values for the state being entered, registered below.
   always_comb begin
      active_d    = (state_d != SNP_IDLE);
      cctrans_d   = 1'b0;
      daddr_d     = '0;
      dstore_d    = '0;
      upd_en_d    = 1'b0;
      upd_idx_d   = '0;
      upd_way_d   = '0;
      upd_valid_d = 1'b0;
      upd_dirty_d = 1'b0;
      case (state_d)
         SNP_XFER0: begin
            cctrans_d = 1'b1;
            daddr_d   = addr_d;
            dstore_d  = data0_d;
         end
         SNP_XFER1: begin
            cctrans_d = 1'b1;
            daddr_d   = addr_d + 32'd4;
            dstore_d  = data1_d;
         end
         SNP_UPDATE: begin
            // Invalidate on a writer's snoop, otherwise downgrade M->S.
            upd_en_d    = 1'b1;
            upd_idx_d   = addr_d[DC_IDX_LSB +: IDX_W];
            upd_way_d   = way_d;
            upd_valid_d = ~inv_d;
         end
         default: begin
            cctrans_d = 1'b0;
         end
      endcase
   end

`ifdef SNOOP_LINK_CLR_EN
   logic link_clr_q, link_clr_d;

   // Link clear: with an invalidate on a frame we write, pulse in UPDATE;
   // with an invalidate that finds nothing to write, pulse on the cycle after
   // the lookup (the first HOLD cycle), since the output is registered.
   always_comb begin
      if (state_d == SNP_UPDATE) begin
         link_clr_d = inv_d;
      end else if (state_q == SNP_LOOKUP) begin
         link_clr_d = ccinv & ~mod_hit_s;
      end else begin
         link_clr_d = 1'b0;
      end
   end

   // Link clear output register.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         link_clr_q <= 1'b0;
      end else begin
         link_clr_q <= link_clr_d;
      end
   end

   assign link_clr = link_clr_q;
`endif

   // FSM state, snoop latches and registered outputs.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= SNP_IDLE;
         addr_q      <= '0;
         inv_q       <= 1'b0;
         way_q       <= '0;
         data0_q     <= '0;
         data1_q     <= '0;
         active_q    <= 1'b0;
         cctrans_q   <= 1'b0;
         daddr_q     <= '0;
         dstore_q    <= '0;
         upd_en_q    <= 1'b0;
         upd_idx_q   <= '0;
         upd_way_q   <= '0;
         upd_valid_q <= 1'b0;
         upd_dirty_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         inv_q       <= inv_d;
         way_q       <= way_d;
         data0_q     <= data0_d;
         data1_q     <= data1_d;
         active_q    <= active_d;
         cctrans_q   <= cctrans_d;
         daddr_q     <= daddr_d;
         dstore_q    <= dstore_d;
         upd_en_q    <= upd_en_d;
         upd_idx_q   <= upd_idx_d;
         upd_way_q   <= upd_way_d;
         upd_valid_q <= upd_valid_d;
         upd_dirty_q <= upd_dirty_d;
      end
   end

   assign snp_addr    = addr_q;
   assign snp_active  = active_q;
   assign snp_cctrans = cctrans_q;
   assign snp_daddr   = daddr_q;
   assign snp_dstore  = dstore_q;
   assign upd_en      = upd_en_q;
   assign upd_idx     = upd_idx_q;
   assign upd_way     = upd_way_q;
   assign upd_valid   = upd_valid_q;
   assign upd_dirty   = upd_dirty_q;

endmodule
